// File: rtl/beep_scheduler.sv
// beep_scheduler: arbitrates click/chime/alarm onto one buzzer as tick-timed on/off bursts
//   clk, rst (sync, active-high); tick timebase strobe; mute gates beep_out only
//   click_req / chime_req+chime_count / alarm_req / alarm_stop request pulses
//   beep_out buzzer enable, busy pattern running, active_src 0 none 1 click 2 chime 3 alarm
module beep_scheduler #(
  parameter int ON_TICKS     = 200,
  parameter int OFF_TICKS    = 200,
  parameter int CLICK_TICKS  = 20,
  parameter int ALARM_BURSTS = 60,
  parameter int CW           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       mute,
  input  logic       click_req,
  input  logic       chime_req,
  input  logic [3:0] chime_count,
  input  logic       alarm_req,
  input  logic       alarm_stop,
  output logic       beep_out,
  output logic       busy,
  output logic [1:0] active_src
);
  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;
  localparam logic [1:0] S_NONE = 2'd0, S_CLICK = 2'd1, S_CHIME = 2'd2, S_ALARM = 2'd3;
  state_t state, state_n;
  logic [1:0] src, src_n;
  logic [CW-1:0] cnt, cnt_n, on_last;
  logic [7:0] left, left_n;
  logic [3:0] chime_cnt, chime_cnt_n, chime_val;
  logic alarm_pend, alarm_pend_n, chime_pend, chime_pend_n;
  logic chime_in, alarm_go, chime_go;
  always_comb begin
    chime_in = chime_req && chime_count != 4'd0;
    chime_val = chime_count > 4'd12 ? 4'd12 : chime_count;
    alarm_go = (alarm_req || alarm_pend) && !alarm_stop;
    on_last = src == S_CLICK ? CW'(CLICK_TICKS - 1) : CW'(ON_TICKS - 1);
    state_n = state;
    src_n = src;
    cnt_n = cnt;
    left_n = left;
    // a running alarm ignores further alarm requests rather than queueing a restart
    alarm_pend_n = alarm_stop ? 1'b0 :
                   (alarm_req && !(state != IDLE && src == S_ALARM)) ? 1'b1 : alarm_pend;
    chime_pend_n = chime_in || chime_pend;
    chime_cnt_n = chime_in ? chime_val : chime_cnt;
    chime_go = chime_pend_n;
    if (state == IDLE) begin
      if (alarm_go) begin
        state_n = ON;
        src_n = S_ALARM;
        cnt_n = '0;
        left_n = 8'(ALARM_BURSTS);
        alarm_pend_n = 1'b0;
      end else if (chime_go) begin
        state_n = ON;
        src_n = S_CHIME;
        cnt_n = '0;
        left_n = {4'd0, chime_cnt_n};
        chime_pend_n = 1'b0;
      end else if (click_req) begin
        state_n = ON;
        src_n = S_CLICK;
        cnt_n = '0;
        left_n = 8'd1;
      end
    end else if (src == S_ALARM && alarm_stop) begin
      state_n = IDLE;
      src_n = S_NONE;
      cnt_n = '0;
      left_n = '0;
    end else if (src != S_ALARM && alarm_go) begin
      // preemption discards the interrupted pattern entirely
      state_n = ON;
      src_n = S_ALARM;
      cnt_n = '0;
      left_n = 8'(ALARM_BURSTS);
      alarm_pend_n = 1'b0;
    end else if (tick) begin
      if (cnt == (state == ON ? on_last : CW'(OFF_TICKS - 1))) begin
        cnt_n = '0;
        if (state == OFF) state_n = ON;
        else begin
          left_n = left - 8'd1;
          state_n = left == 8'd1 ? IDLE : OFF;
          src_n = left == 8'd1 ? S_NONE : src;
        end
      end else cnt_n = cnt + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      src <= S_NONE;
      cnt <= '0;
      left <= '0;
      chime_cnt <= '0;
      alarm_pend <= 1'b0;
      chime_pend <= 1'b0;
      beep_out <= 1'b0;
      busy <= 1'b0;
      active_src <= S_NONE;
    end else begin
      state <= state_n;
      src <= src_n;
      cnt <= cnt_n;
      left <= left_n;
      chime_cnt <= chime_cnt_n;
      alarm_pend <= alarm_pend_n;
      chime_pend <= chime_pend_n;
      beep_out <= state_n == ON && !mute;
      busy <= state_n != IDLE;
      active_src <= src_n;
    end
  end
endmodule

// File: tb/tb_beep_scheduler.sv
// tb_beep_scheduler: directed stimulus, per-cycle check against an elapsed-tick model
module tb_beep_scheduler;
  logic clk = 0, rst = 1, tick = 0, mute = 0, click_req = 0, chime_req = 0;
  logic alarm_req = 0, alarm_stop = 0;
  logic [3:0] chime_count = 0;
  logic beep_out, busy;
  logic [1:0] active_src;
  int total = 0, bad = 0, rises = 0, r0;
  logic prev_beep = 0, armed = 0;

  beep_scheduler #(.ON_TICKS(3), .OFF_TICKS(2), .CLICK_TICKS(1), .ALARM_BURSTS(4), .CW(4)) dut (
    .clk(clk), .rst(rst), .tick(tick), .mute(mute), .click_req(click_req),
    .chime_req(chime_req), .chime_count(chime_count), .alarm_req(alarm_req),
    .alarm_stop(alarm_stop), .beep_out(beep_out), .busy(busy), .active_src(active_src));

  always #5 clk = ~clk;

  // Model: a pattern is n bursts of L ticks with 2-tick gaps; it is described only by
  // the number of ticks elapsed since it started, k, and ends when k reaches n*L+(n-1)*2.
  typedef struct {int src; int k; int n; int cp; int cc; int mute;} mstate_t;
  mstate_t m = '{0, 0, 0, 0, 0, 0};

  function automatic int plen(int s);
    return s == 1 ? 1 : 3;
  endfunction

  function automatic mstate_t nxt(mstate_t c, logic r, logic t, logic mu, logic ck,
                                  logic ch, logic [3:0] cc, logic ar, logic as);
    mstate_t x = c;
    bit aok = ar && !as;
    x.mute = mu;
    if (r) return '{0, 0, 0, 0, 0, 0};
    if (ch && cc != 0) begin
      x.cp = 1;
      x.cc = cc > 12 ? 12 : int'(cc);
    end
    if (c.src == 0) begin
      if (aok) x = '{3, 0, 4, x.cp, x.cc, x.mute};
      else if (x.cp != 0) x = '{2, 0, x.cc, 0, x.cc, x.mute};
      else if (ck) x = '{1, 0, 1, x.cp, x.cc, x.mute};
    end else if (c.src == 3 && as) x.src = 0;
    else if (c.src != 3 && aok) begin
      x.src = 3;
      x.k = 0;
      x.n = 4;
    end else if (t) begin
      x.k = c.k + 1;
      if (x.k == c.n * plen(c.src) + (c.n - 1) * 2) x.src = 0;
    end
    return x;
  endfunction

  always @(posedge clk)
    m <= nxt(m, rst, tick, mute, click_req, chime_req, chime_count, alarm_req, alarm_stop);

  function automatic int exp_out(mstate_t c);
    int on = c.src != 0 && (c.k % (plen(c.src) + 2)) < plen(c.src) && c.mute == 0;
    return (on << 3) | ((c.src != 0) << 2) | c.src;
  endfunction

  always @(negedge clk) begin
    if (beep_out && !prev_beep) rises = rises + 1;
    prev_beep = beep_out;
    if (armed) begin
      total = total + 1;
      if (int'({beep_out, busy, active_src}) != exp_out(m)) begin
        bad = bad + 1;
        $display("FAIL cycle t=%0t {beep,busy,src} got=%0h want=%0h", $time,
                 {beep_out, busy, active_src}, exp_out(m));
      end
    end
  end

  initial begin : tick_gen
    int tc = 0;
    forever begin
      @(posedge clk);
      #1;
      tick = tc == 3;
      tc = (tc + 1) % 4;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int want);
    total = total + 1;
    if (act != want) begin
      bad = bad + 1;
      $display("FAIL %s got=%0d want=%0d", nm, act, want);
    end
  endtask

  task automatic wait_idle(input int bound, input string nm);
    int n = 0;
    while (busy && n < bound) begin
      step();
      n++;
    end
    chk(nm, busy, 0);
  endtask

  task automatic wait_rises(input int target, input int bound, input string nm);
    int n = 0;
    while (rises - r0 < target && n < bound) begin
      step();
      n++;
    end
    chk(nm, rises - r0, target);
  endtask

  initial begin
    step();
    armed = 1;
    step();
    step();
    chk("rst_beep", beep_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_src", active_src, 0);
    rst = 0;
    step();
    // single click, second click during it is dropped
    r0 = rises;
    click_req = 1;
    step();
    click_req = 0;
    chk("click_beep", beep_out, 1);
    chk("click_src", active_src, 1);
    click_req = 1;
    step();
    click_req = 0;
    wait_idle(20, "click_idle");
    repeat (10) step();
    chk("click_rises", rises - r0, 1);
    // chime of 3
    r0 = rises;
    chime_req = 1;
    chime_count = 3;
    step();
    chime_req = 0;
    chk("chime3_src", active_src, 2);
    wait_idle(200, "chime3_idle");
    chk("chime3_rises", rises - r0, 3);
    // count 0 ignored
    r0 = rises;
    chime_req = 1;
    chime_count = 0;
    step();
    chime_req = 0;
    chk("chime0_busy", busy, 0);
    repeat (10) step();
    chk("chime0_rises", rises - r0, 0);
    // count 15 clamps to 12
    r0 = rises;
    chime_req = 1;
    chime_count = 15;
    step();
    chime_req = 0;
    wait_idle(400, "chime15_idle");
    chk("chime15_rises", rises - r0, 12);
    // untouched alarm
    r0 = rises;
    alarm_req = 1;
    step();
    alarm_req = 0;
    chk("alarm_src", active_src, 3);
    wait_idle(200, "alarm_idle");
    chk("alarm_rises", rises - r0, 4);
    // alarm stopped during burst 2
    r0 = rises;
    alarm_req = 1;
    step();
    alarm_req = 0;
    wait_rises(2, 200, "alarm2_wait");
    alarm_stop = 1;
    step();
    alarm_stop = 0;
    chk("stop_beep", beep_out, 0);
    chk("stop_busy", busy, 0);
    // preempt chime by alarm, queue a new chime during the alarm
    r0 = rises;
    chime_req = 1;
    chime_count = 3;
    step();
    chime_req = 0;
    wait_rises(2, 200, "chime_b2_wait");
    alarm_req = 1;
    step();
    alarm_req = 0;
    chk("preempt_src", active_src, 3);
    repeat (5) step();
    chime_req = 1;
    chime_count = 5;
    step();
    chime_req = 0;
    begin
      int n = 0;
      while (active_src == 3 && n < 200) begin
        step();
        n++;
      end
    end
    chk("alarm_end_busy", busy, 0);
    r0 = rises;
    step();
    chk("queued_chime_src", active_src, 2);
    wait_idle(300, "queued_chime_idle");
    chk("queued_chime_rises", rises - r0, 5);
    // reset mid-alarm drops the pending chime as well
    alarm_req = 1;
    step();
    alarm_req = 0;
    chime_req = 1;
    chime_count = 2;
    step();
    chime_req = 0;
    repeat (6) step();
    rst = 1;
    step();
    chk("midrst_beep", beep_out, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_src", active_src, 0);
    rst = 0;
    repeat (10) step();
    chk("midrst_pend_dropped", busy, 0);
    // same-cycle alarm request and stop
    r0 = rises;
    alarm_req = 1;
    alarm_stop = 1;
    step();
    alarm_req = 0;
    alarm_stop = 0;
    chk("req_stop_busy", busy, 0);
    repeat (10) step();
    chk("req_stop_rises", rises - r0, 0);
    // muted click
    r0 = rises;
    mute = 1;
    click_req = 1;
    step();
    click_req = 0;
    chk("mute_busy", busy, 1);
    chk("mute_beep", beep_out, 0);
    wait_idle(20, "mute_idle");
    chk("mute_rises", rises - r0, 0);
    mute = 0;
    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
